// File: rtl/ysyx_exu_trap_ctrl_if.sv
// Bundle between EXU commit, the machine CSR file and the IFU redirect path.
// The master side is the EXU/CSR environment; the slave side is the trap sequencer.
interface ysyx_exu_trap_ctrl_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      in_op;
  logic [XLEN-1:0] in_pc;
  logic            in_csr_wen;
  logic [11:0]     in_csr_addr;
  logic [XLEN-1:0] in_csr_wdata;
  logic            irq_timer;
  logic [XLEN-1:0] csr_mstatus_i;
  logic [XLEN-1:0] csr_mtvec_i;
  logic [XLEN-1:0] csr_mepc_i;
  logic            csr_wen_o;
  logic [11:0]     csr_waddr_o;
  logic [XLEN-1:0] csr_wdata_o;
  logic [11:0]     csr_waddr1_o;
  logic [XLEN-1:0] csr_wdata1_o;
  logic            redirect_o;
  logic [XLEN-1:0] redirect_pc_o;
  logic            busy_o;

  modport master (
    output in_valid, in_op, in_pc, in_csr_wen, in_csr_addr, in_csr_wdata,
           irq_timer, csr_mstatus_i, csr_mtvec_i, csr_mepc_i,
    input  in_ready, csr_wen_o, csr_waddr_o, csr_wdata_o, csr_waddr1_o,
           csr_wdata1_o, redirect_o, redirect_pc_o, busy_o
  );

  modport slave (
    input  in_valid, in_op, in_pc, in_csr_wen, in_csr_addr, in_csr_wdata,
           irq_timer, csr_mstatus_i, csr_mtvec_i, csr_mepc_i,
    output in_ready, csr_wen_o, csr_waddr_o, csr_wdata_o, csr_waddr1_o,
           csr_wdata1_o, redirect_o, redirect_pc_o, busy_o
  );
endinterface

// File: rtl/ysyx_exu_trap_ctrl.sv
// Trap/CSR-write sequencer: owns the CSR file's two write ports, runs trap entry,
// mret and timer-interrupt sequences, and issues a single PC redirect to IFU.
module ysyx_exu_trap_ctrl #(
  parameter int          XLEN     = 32,
  parameter logic [11:0] CSR_NONE = 12'h000
) (
  input  logic                 clk,
  input  logic                 rst,
  ysyx_exu_trap_ctrl_if.slave  bus
);
  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  typedef enum logic [2:0] {IDLE, SAVE, STAT, MRET, REDIR} state_t;

  state_t          state_reg;
  logic [XLEN-1:0] epc_reg;
  logic [XLEN-1:0] cause_reg;
  logic [XLEN-1:0] target_reg;

  logic            idle_ok;
  logic            accept;
  logic            irq_take;
  logic [XLEN-1:0] exc_cause;
  logic [XLEN-1:0] trap_base;
  logic [XLEN-1:0] trap_target;
  logic [XLEN-1:0] mstatus_trap;
  logic [XLEN-1:0] mstatus_mret;

  // in_ready is derived without going through accept to keep the handshake loop-free.
  assign idle_ok  = (state_reg == IDLE) && !rst;
  assign accept   = bus.in_valid && idle_ok;
  assign irq_take = bus.irq_timer && bus.csr_mstatus_i[3];

  always_comb begin
    exc_cause = XLEN'(2);
    case (bus.in_op)
      3'd1:    exc_cause = XLEN'(11);
      3'd2:    exc_cause = XLEN'(3);
      default: exc_cause = XLEN'(2);
    endcase
  end

  // Vectored mode only applies to interrupts; exceptions always land on the base.
  always_comb begin
    trap_base   = {bus.csr_mtvec_i[XLEN-1:2], 2'b00};
    trap_target = trap_base;
    if (bus.csr_mtvec_i[1:0] == 2'b01 && cause_reg[XLEN-1])
      trap_target = trap_base + {cause_reg[XLEN-3:0], 2'b00};
  end

  always_comb begin
    mstatus_trap        = bus.csr_mstatus_i;
    mstatus_trap[7]     = bus.csr_mstatus_i[3];
    mstatus_trap[3]     = 1'b0;
    mstatus_trap[12:11] = 2'b11;
    mstatus_mret        = bus.csr_mstatus_i;
    mstatus_mret[3]     = bus.csr_mstatus_i[7];
    mstatus_mret[7]     = 1'b1;
    mstatus_mret[12:11] = 2'b11;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      epc_reg    <= '0;
      cause_reg  <= '0;
      target_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            if (irq_take) begin
              epc_reg   <= bus.in_pc;
              cause_reg <= {1'b1, (XLEN-1)'(7)};
              state_reg <= SAVE;
            end else if (bus.in_op == 3'd3) begin
              state_reg <= MRET;
            end else if (bus.in_op != 3'd0) begin
              epc_reg   <= bus.in_pc;
              cause_reg <= exc_cause;
              state_reg <= SAVE;
            end
          end
        end
        SAVE: begin
          target_reg <= trap_target;
          state_reg  <= STAT;
        end
        STAT:  state_reg <= REDIR;
        MRET: begin
          target_reg <= bus.csr_mepc_i;
          state_reg  <= REDIR;
        end
        REDIR:   state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_comb begin
    bus.in_ready      = idle_ok;
    bus.busy_o        = (state_reg != IDLE) && !rst;
    bus.csr_wen_o     = 1'b0;
    bus.csr_waddr_o   = CSR_NONE;
    bus.csr_wdata_o   = '0;
    bus.csr_waddr1_o  = CSR_NONE;
    bus.csr_wdata1_o  = '0;
    bus.redirect_o    = 1'b0;
    bus.redirect_pc_o = '0;
    if (!rst) begin
      case (state_reg)
        IDLE: begin
          if (accept && !irq_take && bus.in_op == 3'd0 && bus.in_csr_wen) begin
            bus.csr_wen_o   = 1'b1;
            bus.csr_waddr_o = bus.in_csr_addr;
            bus.csr_wdata_o = bus.in_csr_wdata;
          end
        end
        SAVE: begin
          bus.csr_wen_o    = 1'b1;
          bus.csr_waddr_o  = CSR_MEPC;
          bus.csr_wdata_o  = epc_reg;
          bus.csr_waddr1_o = CSR_MCAUSE;
          bus.csr_wdata1_o = cause_reg;
        end
        STAT: begin
          bus.csr_wen_o   = 1'b1;
          bus.csr_waddr_o = CSR_MSTATUS;
          bus.csr_wdata_o = mstatus_trap;
        end
        MRET: begin
          bus.csr_wen_o   = 1'b1;
          bus.csr_waddr_o = CSR_MSTATUS;
          bus.csr_wdata_o = mstatus_mret;
        end
        REDIR: begin
          bus.redirect_o    = 1'b1;
          bus.redirect_pc_o = target_reg;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ysyx_exu_trap_ctrl.sv
// Directed bench for the trap sequencer: inputs change on the falling edge,
// outputs are checked 1 ns later, well away from the rising edge.
module tb_ysyx_exu_trap_ctrl;
  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  ysyx_exu_trap_ctrl_if #(.XLEN(32)) bus ();

  ysyx_exu_trap_ctrl #(.XLEN(32), .CSR_NONE(12'h000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] pc,
                       input logic wen, input logic [11:0] addr, input logic [31:0] data);
    bus.in_valid     = v;
    bus.in_op        = op;
    bus.in_pc        = pc;
    bus.in_csr_wen   = wen;
    bus.in_csr_addr  = addr;
    bus.in_csr_wdata = data;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 3'd0, 32'h0, 1'b0, 12'h0, 32'h0);
    bus.irq_timer     = 1'b0;
    bus.csr_mstatus_i = 32'h0000_0008;
    bus.csr_mtvec_i   = 32'h8000_1000;
    bus.csr_mepc_i    = 32'h0;

    // Reset state
    step(); step(); #1;
    chk("rst_ready", 32'(bus.in_ready), 32'h0);
    chk("rst_wen", 32'(bus.csr_wen_o), 32'h0);
    chk("rst_waddr", 32'(bus.csr_waddr_o), 32'h0);
    chk("rst_redir", 32'(bus.redirect_o), 32'h0);
    step(); rst = 1'b0; #1;
    chk("idle_ready", 32'(bus.in_ready), 32'h1);
    chk("idle_busy", 32'(bus.busy_o), 32'h0);

    // Plain CSR write, same cycle
    step(); drive(1'b1, 3'd0, 32'h8000_0000, 1'b1, 12'h305, 32'h8000_0100); #1;
    chk("plain_wen", 32'(bus.csr_wen_o), 32'h1);
    chk("plain_waddr", 32'(bus.csr_waddr_o), 32'h305);
    chk("plain_wdata", bus.csr_wdata_o, 32'h8000_0100);
    chk("plain_waddr1", 32'(bus.csr_waddr1_o), 32'h0);
    step(); drive(1'b1, 3'd0, 32'h8000_0004, 1'b0, 12'h305, 32'h1); #1;
    chk("plain_busy", 32'(bus.busy_o), 32'h0);
    chk("plain_nowen", 32'(bus.csr_wen_o), 32'h0);
    step(); drive(1'b0, 3'd0, 32'h8000_0008, 1'b1, 12'h305, 32'h1); #1;
    chk("novalid_nowen", 32'(bus.csr_wen_o), 32'h0);

    // ecall with back-pressure; mstatus has a pass-through bit 17
    bus.csr_mstatus_i = 32'h0002_0008;
    step(); drive(1'b1, 3'd1, 32'h8000_0040, 1'b0, 12'h0, 32'h0); #1;
    chk("ecall_acc_ready", 32'(bus.in_ready), 32'h1);
    chk("ecall_acc_wen", 32'(bus.csr_wen_o), 32'h0);
    step(); #1;
    chk("save_ready", 32'(bus.in_ready), 32'h0);
    chk("save_busy", 32'(bus.busy_o), 32'h1);
    chk("save_wen", 32'(bus.csr_wen_o), 32'h1);
    chk("save_waddr", 32'(bus.csr_waddr_o), 32'h341);
    chk("save_mepc", bus.csr_wdata_o, 32'h8000_0040);
    chk("save_waddr1", 32'(bus.csr_waddr1_o), 32'h342);
    chk("save_mcause", bus.csr_wdata1_o, 32'h0000_000B);
    step(); #1;
    chk("stat_ready", 32'(bus.in_ready), 32'h0);
    chk("stat_waddr", 32'(bus.csr_waddr_o), 32'h300);
    chk("stat_mstatus", bus.csr_wdata_o, 32'h0002_1880);
    chk("stat_waddr1", 32'(bus.csr_waddr1_o), 32'h0);
    chk("stat_redir", 32'(bus.redirect_o), 32'h0);
    step(); #1;
    chk("redir_pulse", 32'(bus.redirect_o), 32'h1);
    chk("redir_pc", bus.redirect_pc_o, 32'h8000_1000);
    chk("redir_ready", 32'(bus.in_ready), 32'h0);
    chk("redir_wen", 32'(bus.csr_wen_o), 32'h0);
    step(); drive(1'b0, 3'd0, 32'h0, 1'b0, 12'h0, 32'h0); #1;
    chk("post_ready", 32'(bus.in_ready), 32'h1);
    chk("post_redir", 32'(bus.redirect_o), 32'h0);

    // Vectored timer interrupt beats a plain write
    bus.csr_mstatus_i = 32'h0000_0008;
    bus.csr_mtvec_i   = 32'h8000_1001;
    bus.irq_timer     = 1'b1;
    step(); drive(1'b1, 3'd0, 32'h8000_0200, 1'b1, 12'h305, 32'h1234); #1;
    chk("irq_acc_wen", 32'(bus.csr_wen_o), 32'h0);
    step(); drive(1'b0, 3'd0, 32'h0, 1'b0, 12'h0, 32'h0); #1;
    chk("irq_mepc", bus.csr_wdata_o, 32'h8000_0200);
    chk("irq_mcause", bus.csr_wdata1_o, 32'h8000_0007);
    step(); #1;
    chk("irq_stat", bus.csr_wdata_o, 32'h0000_1880);
    bus.csr_mstatus_i = 32'h0000_1880;
    step(); #1;
    chk("irq_redir_pc", bus.redirect_pc_o, 32'h8000_101C);
    // irq still high but MIE=0: instruction proceeds
    step(); drive(1'b1, 3'd0, 32'h8000_101C, 1'b1, 12'h340, 32'hABCD); #1;
    chk("irq_masked_wen", 32'(bus.csr_wen_o), 32'h1);
    step(); drive(1'b0, 3'd0, 32'h0, 1'b0, 12'h0, 32'h0); #1;
    chk("irq_masked_busy", 32'(bus.busy_o), 32'h0);
    bus.irq_timer = 1'b0;

    // ebreak with vectored mtvec still targets the base
    bus.csr_mstatus_i = 32'h0000_0008;
    step(); drive(1'b1, 3'd2, 32'h8000_0050, 1'b0, 12'h0, 32'h0); #1;
    step(); drive(1'b0, 3'd0, 32'h0, 1'b0, 12'h0, 32'h0); #1;
    chk("ebreak_mcause", bus.csr_wdata1_o, 32'h0000_0003);
    step(); step(); #1;
    chk("ebreak_redir_pc", bus.redirect_pc_o, 32'h8000_1000);

    // mret
    bus.csr_mstatus_i = 32'h0000_0080;
    bus.csr_mepc_i    = 32'h8000_0044;
    step(); drive(1'b1, 3'd3, 32'h8000_1010, 1'b0, 12'h0, 32'h0); #1;
    step(); drive(1'b0, 3'd0, 32'h0, 1'b0, 12'h0, 32'h0); #1;
    chk("mret_wen", 32'(bus.csr_wen_o), 32'h1);
    chk("mret_waddr", 32'(bus.csr_waddr_o), 32'h300);
    chk("mret_mstatus", bus.csr_wdata_o, 32'h0000_1888);
    chk("mret_waddr1", 32'(bus.csr_waddr1_o), 32'h0);
    step(); #1;
    chk("mret_redir", 32'(bus.redirect_o), 32'h1);
    chk("mret_redir_pc", bus.redirect_pc_o, 32'h8000_0044);
    step(); #1;
    chk("mret_post_ready", 32'(bus.in_ready), 32'h1);

    // op 6 treated as illegal, then reset lands in STAT
    bus.csr_mstatus_i = 32'h0000_0008;
    bus.csr_mtvec_i   = 32'h8000_1000;
    step(); drive(1'b1, 3'd6, 32'h8000_0300, 1'b0, 12'h0, 32'h0); #1;
    step(); drive(1'b0, 3'd0, 32'h0, 1'b0, 12'h0, 32'h0); #1;
    chk("illegal_mcause", bus.csr_wdata1_o, 32'h0000_0002);
    step(); rst = 1'b1; #1;
    chk("rst_stat_wen", 32'(bus.csr_wen_o), 32'h0);
    step(); rst = 1'b0; #1;
    chk("rst_stat_busy", 32'(bus.busy_o), 32'h0);
    chk("rst_stat_ready", 32'(bus.in_ready), 32'h1);
    chk("rst_stat_redir", 32'(bus.redirect_o), 32'h0);
    chk("rst_stat_wen2", 32'(bus.csr_wen_o), 32'h0);
    step(); #1;
    chk("rst_stat_redir2", 32'(bus.redirect_o), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
